// File: rtl/cby_tile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cby_tile_pkg
//  Brief    : Shared types, sizing functions and configuration layout offsets
//             for the Y connection-block tile.
//  Revision : 1.0 - initial release
// ============================================================================
package cby_tile_pkg;

    // Configuration-load state machine encoding.
    typedef enum logic [1:0] {
        ST_UNCONF  = 2'd0,
        ST_LOADING = 2'd1,
        ST_ACTIVE  = 2'd2
    } cfg_state_t;

    // Grid selects start at the bottom of the flat configuration image.
    localparam int c_GRID_SEL_OFS = 0;

    // Select width: codes 0 .. 2*CHAN_W must be representable.
    function automatic int calc_sel_w(input int chan_w);
        return $clog2(2 * chan_w + 1);
    endfunction

    // Meaningful configuration bits: one select per grid pin and pad, plus one oe bit per pad.
    function automatic int calc_cfg_bits(input int grid_pins, input int num_io, input int sel_w);
        return (grid_pins + num_io) * sel_w + num_io;
    endfunction

    // Number of config words needed to hold the image (rounded up).
    function automatic int calc_num_wl(input int cfg_bits, input int bl_w);
        return (cfg_bits + bl_w - 1) / bl_w;
    endfunction

    // Pad-out selects follow the grid selects.
    function automatic int calc_pad_sel_ofs(input int grid_pins, input int sel_w);
        return c_GRID_SEL_OFS + grid_pins * sel_w;
    endfunction

    // Output-enable bits follow the pad-out selects.
    function automatic int calc_oe_ofs(input int grid_pins, input int num_io, input int sel_w);
        return c_GRID_SEL_OFS + (grid_pins + num_io) * sel_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cby_track_mux.sv
`default_nettype none
// ============================================================================
//  Module   : cby_track_mux
//  Brief    : One routing multiplexer: select 0 gives constant 0, 1..CHAN_W
//             picks a bottom track, CHAN_W+1..2*CHAN_W picks a top track,
//             any larger code gives constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module cby_track_mux
    import cby_tile_pkg::*;
#(
    parameter  int CHAN_W = 20,
    localparam int SEL_W  = calc_sel_w(CHAN_W)
) (
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [CHAN_W-1:0] i_bottom,
    input  logic [CHAN_W-1:0] i_top,
    output logic              o_track
);

    localparam int c_NUM_SRC = 2 * CHAN_W + 1;

    // Source vector indexed directly by the select code; bit 0 is the constant-0 source.
    logic [c_NUM_SRC-1:0] w_src;
    assign w_src = {i_top, i_bottom, 1'b0};

    // Decode the select; codes beyond the last top track fall back to 0.
    always_comb begin
        o_track = 1'b0;
        if (int'(i_sel) < c_NUM_SRC) begin
            o_track = w_src[i_sel];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cby_tile_param.sv
`default_nettype none
// ============================================================================
//  Module   : cby_tile_param
//  Brief    : Parameterised Y connection-block tile with word-addressed
//             configuration memory, load-sequencing FSM, grid-pin and pad
//             routing muxes and straight-through channel tracks.
//             Optional macro CBY_CFG_READBACK_EN adds a registered
//             configuration readback port (rd_wl / rd_bl).
//  Revision : 1.0 - initial release
// ============================================================================
module cby_tile_param
    import cby_tile_pkg::*;
#(
    parameter  int CHAN_W    = 20,
    parameter  int GRID_PINS = 10,
    parameter  int NUM_IO    = 8,
    parameter  int BL_W      = 8,
    localparam int SEL_W     = calc_sel_w(CHAN_W),
    localparam int CFG_BITS  = calc_cfg_bits(GRID_PINS, NUM_IO, SEL_W),
    localparam int NUM_WL    = calc_num_wl(CFG_BITS, BL_W)
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic [BL_W-1:0]      bl,
    input  logic [NUM_WL-1:0]    wl,
    input  logic                 cfg_done,
    input  logic [CHAN_W-1:0]    chany_bottom_in,
    input  logic [CHAN_W-1:0]    chany_top_in,
    output logic [CHAN_W-1:0]    chany_top_out,
    output logic [CHAN_W-1:0]    chany_bottom_out,
    output logic [GRID_PINS-1:0] grid_right_out,
    input  logic [NUM_IO-1:0]    pad_in,
    output logic [NUM_IO-1:0]    pad_out,
    output logic [NUM_IO-1:0]    pad_oe,
    output logic [NUM_IO-1:0]    io_right_in,
    output logic                 cfg_active,
    output logic                 cfg_err
`ifdef CBY_CFG_READBACK_EN
    ,
    input  logic [NUM_WL-1:0]    rd_wl,
    output logic [BL_W-1:0]      rd_bl
`endif
);

    localparam int c_STORE_W = NUM_WL * BL_W;
    localparam int c_PAD_OFS = calc_pad_sel_ofs(GRID_PINS, SEL_W);
    localparam int c_OE_OFS  = calc_oe_ofs(GRID_PINS, NUM_IO, SEL_W);

    cfg_state_t             r_state;
    cfg_state_t             w_state_next;
    logic [c_STORE_W-1:0]   r_cfg;
    logic [c_STORE_W-1:0]   w_unused_cfg;
    logic [NUM_WL-1:0]      r_mask;
    logic [NUM_WL-1:0]      w_mask_next;
    logic                   r_err;
    logic                   w_err_set;
    logic                   w_wl_onehot;
    logic                   w_wl_any;
    logic                   w_wr_en;
    logic                   w_active;
    logic [GRID_PINS-1:0]   w_grid_raw;
    logic [NUM_IO-1:0]      w_pad_raw;
    logic [NUM_IO-1:0]      w_oe_raw;

    // Write qualification: only a one-hot word select writes, and never once configured.
    assign w_wl_onehot = $onehot(wl);
    assign w_wl_any    = |wl;
    assign w_wr_en     = w_wl_onehot && (r_state != ST_ACTIVE);
    // Mask as it will be after this edge, so a write coinciding with cfg_done counts.
    assign w_mask_next = w_wr_en ? (r_mask | wl) : r_mask;

    // Next-state and error detection for the configuration load sequence.
    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        if (w_wl_any && !w_wl_onehot) begin
            w_err_set = 1'b1;
        end
        case (r_state)
            ST_UNCONF: begin
                if (w_wr_en) begin
                    w_state_next = ST_LOADING;
                end
                if (cfg_done) begin
                    w_err_set = 1'b1;
                end
            end
            ST_LOADING: begin
                if (cfg_done) begin
                    if (&w_mask_next) begin
                        w_state_next = ST_ACTIVE;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_wl_any) begin
                    w_err_set = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_UNCONF;
            end
        endcase
    end

    // State register; reset overrides any simultaneous write or cfg_done.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= ST_UNCONF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Configuration words and written mask.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_cfg  <= '0;
            r_mask <= '0;
        end else if (w_wr_en) begin
            for (int w = 0; w < NUM_WL; w++) begin
                if (wl[w]) begin
                    r_cfg[w*BL_W +: BL_W] <= bl;
                end
            end
            r_mask <= w_mask_next;
        end
    end

    // Sticky error flag.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    // Padding bits above the layout are stored only for readback; this alias consumes them.
    assign w_unused_cfg = r_cfg;

    // One mux per grid pin.
    generate
        for (genvar gi = 0; gi < GRID_PINS; gi++) begin : g_grid_mux
            cby_track_mux #(
                .CHAN_W (CHAN_W)
            ) u_mux (
                .i_sel    (r_cfg[c_GRID_SEL_OFS + gi*SEL_W +: SEL_W]),
                .i_bottom (chany_bottom_in),
                .i_top    (chany_top_in),
                .o_track  (w_grid_raw[gi])
            );
        end
    endgenerate

    // One mux per pad output.
    generate
        for (genvar pi = 0; pi < NUM_IO; pi++) begin : g_pad_mux
            cby_track_mux #(
                .CHAN_W (CHAN_W)
            ) u_mux (
                .i_sel    (r_cfg[c_PAD_OFS + pi*SEL_W +: SEL_W]),
                .i_bottom (chany_bottom_in),
                .i_top    (chany_top_in),
                .o_track  (w_pad_raw[pi])
            );
        end
    endgenerate

    assign w_oe_raw = r_cfg[c_OE_OFS +: NUM_IO];
    assign w_active = (r_state == ST_ACTIVE);

    // Routed outputs are held at 0 until the tile is fully configured.
    assign grid_right_out = w_active ? w_grid_raw : '0;
    assign pad_out        = w_active ? w_pad_raw : '0;
    assign pad_oe         = w_active ? w_oe_raw : '0;
    assign io_right_in    = w_active ? (pad_in & ~w_oe_raw) : '0;

    // Channel tracks pass straight through regardless of configuration state.
    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;

    assign cfg_active = w_active;
    assign cfg_err    = r_err;

`ifdef CBY_CFG_READBACK_EN
    logic [BL_W-1:0] r_rd_bl;
    logic [BL_W-1:0] w_rd_word;

    // Select the addressed word; a non-one-hot address reads as 0.
    always_comb begin
        w_rd_word = '0;
        if ($onehot(rd_wl)) begin
            for (int w = 0; w < NUM_WL; w++) begin
                if (rd_wl[w]) begin
                    w_rd_word = r_cfg[w*BL_W +: BL_W];
                end
            end
        end
    end

    // Readback data register, one cycle behind rd_wl.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_rd_bl <= '0;
        end else begin
            r_rd_bl <= w_rd_word;
        end
    end

    assign rd_bl = r_rd_bl;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cby_tile_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cby_tile_param
//  Brief    : Self-checking bench for cby_tile_param (default parameters).
//             Stimulus pushes expected values into a scoreboard queue; a
//             monitor on the falling clock edge pops and compares them.
//             Define CBY_CFG_READBACK_EN to include the readback checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cby_tile_param;

    localparam int CHAN_W    = 20;
    localparam int GRID_PINS = 10;
    localparam int NUM_IO    = 8;
    localparam int BL_W      = 8;
    localparam int NUM_WL    = 15;
    localparam int IMG_W     = NUM_WL * BL_W;

    logic                 prog_clk = 1'b0;
    logic                 pReset;
    logic [BL_W-1:0]      bl;
    logic [NUM_WL-1:0]    wl;
    logic                 cfg_done;
    logic [CHAN_W-1:0]    chany_bottom_in;
    logic [CHAN_W-1:0]    chany_top_in;
    logic [CHAN_W-1:0]    chany_top_out;
    logic [CHAN_W-1:0]    chany_bottom_out;
    logic [GRID_PINS-1:0] grid_right_out;
    logic [NUM_IO-1:0]    pad_in;
    logic [NUM_IO-1:0]    pad_out;
    logic [NUM_IO-1:0]    pad_oe;
    logic [NUM_IO-1:0]    io_right_in;
    logic                 cfg_active;
    logic                 cfg_err;
`ifdef CBY_CFG_READBACK_EN
    logic [NUM_WL-1:0]    rd_wl;
    logic [BL_W-1:0]      rd_bl;
`endif

    cby_tile_param #(
        .CHAN_W    (CHAN_W),
        .GRID_PINS (GRID_PINS),
        .NUM_IO    (NUM_IO),
        .BL_W      (BL_W)
    ) dut (
        .prog_clk         (prog_clk),
        .pReset           (pReset),
        .bl               (bl),
        .wl               (wl),
        .cfg_done         (cfg_done),
        .chany_bottom_in  (chany_bottom_in),
        .chany_top_in     (chany_top_in),
        .chany_top_out    (chany_top_out),
        .chany_bottom_out (chany_bottom_out),
        .grid_right_out   (grid_right_out),
        .pad_in           (pad_in),
        .pad_out          (pad_out),
        .pad_oe           (pad_oe),
        .io_right_in      (io_right_in),
        .cfg_active       (cfg_active),
        .cfg_err          (cfg_err)
`ifdef CBY_CFG_READBACK_EN
        ,
        .rd_wl            (rd_wl),
        .rd_bl            (rd_bl)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    typedef enum int {K_GRID, K_PADOUT, K_PADOE, K_IO, K_ACT, K_ERR, K_TOP, K_BOT, K_RD} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [IMG_W-1:0] img;

    task automatic expect_val(input kind_t k, input string nm, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.name = nm;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] dut_val(input kind_t k);
        case (k)
            K_GRID:   return 32'(grid_right_out);
            K_PADOUT: return 32'(pad_out);
            K_PADOE:  return 32'(pad_oe);
            K_IO:     return 32'(io_right_in);
            K_ACT:    return 32'(cfg_active);
            K_ERR:    return 32'(cfg_err);
            K_TOP:    return 32'(chany_top_out);
            K_BOT:    return 32'(chany_bottom_out);
`ifdef CBY_CFG_READBACK_EN
            K_RD:     return 32'(rd_bl);
`endif
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation queued during this cycle.
    always @(negedge prog_clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = dut_val(mon_e.kind);
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: actual=%0h expected=%0h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic write_word(input int w, input logic [BL_W-1:0] d);
        wl    = '0;
        wl[w] = 1'b1;
        bl    = d;
        cyc();
        wl    = '0;
    endtask

    task automatic do_reset();
        pReset = 1'b1;
        cyc();
        pReset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        pReset = 1'b1; bl = '0; wl = '0; cfg_done = 1'b0;
        chany_bottom_in = 20'hABCDE;
        chany_top_in    = 20'h12345;
        pad_in          = 8'hFF;
`ifdef CBY_CFG_READBACK_EN
        rd_wl = '0;
`endif
        // Image: grid0 sel=3, grid1 sel=21, pad2 sel=1, pad3 sel=2, pad4 sel=63, oe[2]=1.
        img = '0;
        img[0*6 +: 6]      = 6'd3;
        img[1*6 +: 6]      = 6'd21;
        img[60 + 2*6 +: 6] = 6'd1;
        img[60 + 3*6 +: 6] = 6'd2;
        img[60 + 4*6 +: 6] = 6'd63;
        img[108 + 2]       = 1'b1;

        cyc(); cyc();
        // Reset state (reset still held).
        expect_val(K_ACT,   "reset_active", 0);
        expect_val(K_ERR,   "reset_err",    0);
        expect_val(K_GRID,  "reset_grid",   0);
        expect_val(K_PADOE, "reset_oe",     0);
        expect_val(K_IO,    "reset_io",     0);
        expect_val(K_TOP,   "pass_top",     32'hABCDE);
        expect_val(K_BOT,   "pass_bot",     32'h12345);
        pReset = 1'b0;
        cyc();

        // Full load: 15 words then cfg_done.
        for (int w = 0; w < NUM_WL; w++) write_word(w, img[w*BL_W +: BL_W]);
        expect_val(K_ACT,  "load_active_pre",  0);
        expect_val(K_ERR,  "load_err_pre",     0);
        expect_val(K_GRID, "load_grid_pre",    0);
        cfg_done = 1'b1;
        expect_val(K_ACT,  "done_same_cycle",  0);
        cyc();
        cfg_done = 1'b0;
        expect_val(K_ACT,  "active_after_done", 1);
        expect_val(K_ERR,  "err_after_load",    0);
        // bottom=ABCDE: b[2]=1, b[1]=1, b[0]=0; top=12345: t[0]=1.
        expect_val(K_GRID,   "grid_p1",  32'h003);
        expect_val(K_PADOUT, "padout_p1", 32'h08);
        expect_val(K_PADOE,  "oe_p1",     32'h04);
        expect_val(K_IO,     "io_p1",     32'hFB);
        cyc();
        chany_bottom_in = 20'h00003; chany_top_in = 20'h00000; pad_in = 8'h0C;
        expect_val(K_GRID,   "grid_p2",   32'h000);
        expect_val(K_PADOUT, "padout_p2", 32'h0C);
        expect_val(K_IO,     "io_p2",     32'h08);
        cyc();
        chany_bottom_in = 20'h00004; chany_top_in = 20'h00001;
        expect_val(K_GRID,   "grid_p3",   32'h003);
        expect_val(K_PADOUT, "padout_p3", 32'h00);
        cyc();
        chany_bottom_in = 20'hFFFFF; chany_top_in = 20'hFFFFE;
        expect_val(K_GRID,   "grid_p4",   32'h001);
        expect_val(K_PADOUT, "padout_p4", 32'h0C);

        // Write while ACTIVE: ignored, sets cfg_err.
        write_word(0, 8'h00);
        expect_val(K_ERR,  "active_write_err",   1);
        expect_val(K_GRID, "active_write_ignored", 32'h001);
        expect_val(K_ACT,  "active_write_state", 1);

        // Reset while ACTIVE.
        pReset = 1'b1;
        cyc();
        pReset = 1'b0;
        expect_val(K_GRID,   "rst_grid",   0);
        expect_val(K_PADOUT, "rst_padout", 0);
        expect_val(K_PADOE,  "rst_oe",     0);
        expect_val(K_IO,     "rst_io",     0);
        expect_val(K_ACT,    "rst_active", 0);
        expect_val(K_ERR,    "rst_err",    0);
        expect_val(K_TOP,    "rst_pass_top", 32'hFFFFF);
        expect_val(K_BOT,    "rst_pass_bot", 32'hFFFFE);
        cyc();

        // Early done: 14 words, cfg_done, then word 14 together with cfg_done.
        chany_bottom_in = 20'h00004; chany_top_in = 20'h00001;
        for (int w = 0; w < NUM_WL - 1; w++) write_word(w, img[w*BL_W +: BL_W]);
        cfg_done = 1'b1;
        cyc();
        cfg_done = 1'b0;
        expect_val(K_ACT,  "early_active", 0);
        expect_val(K_ERR,  "early_err",    1);
        expect_val(K_GRID, "early_grid",   0);
        cyc();
        wl = '0; wl[NUM_WL-1] = 1'b1; bl = img[(NUM_WL-1)*BL_W +: BL_W];
        cfg_done = 1'b1;
        cyc();
        wl = '0; cfg_done = 1'b0;
        expect_val(K_ACT,  "late_active", 1);
        expect_val(K_GRID, "late_grid",   32'h003);
        cyc();

        // cfg_done in UNCONF.
        do_reset();
        cfg_done = 1'b1;
        cyc();
        cfg_done = 1'b0;
        expect_val(K_ERR, "unconf_done_err",    1);
        expect_val(K_ACT, "unconf_done_active", 0);
        cyc();

        // Multi-bit wl: ignored, error next cycle, mask unchanged.
        do_reset();
        wl = 15'h0003; bl = 8'hFF;
        expect_val(K_ERR, "badwl_err_before", 0);
        cyc();
        wl = '0;
        expect_val(K_ERR, "badwl_err_after", 1);
`ifdef CBY_CFG_READBACK_EN
        rd_wl = 15'h0001;
        cyc();
        expect_val(K_RD, "badwl_word0", 0);
        rd_wl = 15'h0002;
        cyc();
        expect_val(K_RD, "badwl_word1", 0);
        rd_wl = '0;
`endif
        for (int w = 2; w < NUM_WL; w++) write_word(w, img[w*BL_W +: BL_W]);
        cfg_done = 1'b1;
        cyc();
        cfg_done = 1'b0;
        expect_val(K_ACT, "badwl_mask_incomplete", 0);
        cyc();

`ifdef CBY_CFG_READBACK_EN
        // Readback of a written word, then a non-one-hot address.
        do_reset();
        write_word(4, 8'hA5);
        rd_wl = 15'h0010;
        expect_val(K_RD, "rd_before", 0);
        cyc();
        expect_val(K_RD, "rd_word4", 32'hA5);
        rd_wl = 15'h0011;
        cyc();
        expect_val(K_RD, "rd_not_onehot", 0);
        rd_wl = '0;
`endif

        cyc(); cyc();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d expected=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cby_tile_param.md
CBY_TILE_PARAM -- requirements
Module: cby_tile_param

Interface
REQ-001 SHALL have parameter CHAN_W, default 20, Y-channel tracks per direction.
REQ-002 SHALL have parameter GRID_PINS, default 10, grid input pins driven by the block.
REQ-003 SHALL have parameter NUM_IO, default 8, IO pads owned by the tile.
REQ-004 SHALL have parameter BL_W, default 8, config word width.
REQ-005 SHALL use derived constants: SEL_W = clog2(2*CHAN_W+1); CFG_BITS = (GRID_PINS+NUM_IO)*SEL_W + NUM_IO; NUM_WL = ceil(CFG_BITS/BL_W).
REQ-006 SHALL use one clock and synchronous active-high reset: prog_clk  input  1  configuration clock; pReset  input  1  reset.
REQ-007 SHALL have port bl  input  BL_W  write data.
REQ-008 SHALL have port wl  input  NUM_WL  one-hot word select; all-zero = no write.
REQ-009 SHALL have port cfg_done  input  1  end-of-load pulse.
REQ-010 SHALL have port chany_bottom_in / chany_top_in  input  CHAN_W each  channel tracks.
REQ-011 SHALL have port chany_top_out / chany_bottom_out  output  CHAN_W each  pass-through tracks.
REQ-012 SHALL have port grid_right_out  output  GRID_PINS  routed grid pins.
REQ-013 SHALL have port pad_in  input  NUM_IO, pad_out  output  NUM_IO, pad_oe  output  NUM_IO; tristate is resolved at top level.
REQ-014 SHALL have port io_right_in  output  NUM_IO  pad value into fabric.
REQ-015 SHALL have ports cfg_active  output  1 and cfg_err  output  1 (sticky).

Function
REQ-016 SHALL store NUM_WL x BL_W config words; flat bit index = word*BL_W + bit. Bits at or above CFG_BITS are stored but ignored.
REQ-017 SHALL use this flat layout: grid selects [GRID_PINS*SEL_W-1:0], then pad-out selects, then NUM_IO oe bits.
REQ-018 SHALL decode select s as: 0 -> constant 0; 1..CHAN_W -> chany_bottom_in[s-1]; CHAN_W+1..2*CHAN_W -> chany_top_in[s-1-CHAN_W]; above 2*CHAN_W -> constant 0.
REQ-019 SHALL drive chany_top_out = chany_bottom_in and chany_bottom_out = chany_top_in combinationally in every state.
REQ-020 SHALL implement FSM UNCONF -> LOADING on the first valid write; LOADING -> ACTIVE on cfg_done when all NUM_WL words are written.
REQ-021 SHALL treat a write as valid only when wl is exactly one-hot; the word is written at the next prog_clk edge and its written-mask bit is set.
REQ-022 SHALL ignore a wl with more than one bit set, and SHALL set cfg_err the following cycle.
REQ-023 SHALL, on cfg_done while the mask is incomplete, or while in UNCONF, stay in the current state and set cfg_err.
REQ-024 SHALL ignore writes in ACTIVE and set cfg_err.
REQ-025 SHALL, on a write coinciding with cfg_done in LOADING, perform the write first; the completeness check includes that word.
REQ-026 SHALL register cfg_active (=state ACTIVE), so it is high one cycle after the qualifying cfg_done edge.
REQ-027 SHALL, when not ACTIVE, force grid_right_out, pad_out, pad_oe and io_right_in to 0.
REQ-028 SHALL, in ACTIVE, route combinationally per REQ-018: pad_oe[i] = oe bit; io_right_in[i] = pad_in[i] & ~pad_oe[i].

Reset
REQ-029 SHALL, on pReset, clear config words, written mask and cfg_err, set state UNCONF, and set cfg_active=0; pReset has priority over any simultaneous write or cfg_done.
REQ-030 SHALL, on pReset asserted in LOADING or ACTIVE, discard the configuration at the same edge and force outputs to 0 from the next cycle.

Configuration
REQ-031 SHALL support macro CBY_CFG_READBACK_EN. When defined, it adds ports rd_wl (input NUM_WL, one-hot) and rd_bl (output BL_W). rd_bl is registered: the selected word appears one cycle after rd_wl, is 0 for a non-one-hot rd_wl, and resets to 0.
REQ-032 SHALL omit both ports and their logic when CBY_CFG_READBACK_EN is undefined; all other behaviour is identical.

Structure
REQ-033 SHALL place the FSM state enum, the SEL_W/CFG_BITS/NUM_WL computation functions and the layout offset constants in a shared package cby_tile_pkg.
REQ-034 SHALL implement the select decode of REQ-018 in one sub-module cby_track_mux (parameter CHAN_W), instantiated GRID_PINS+NUM_IO times.

Verification (defaults, SEL_W=6, CFG_BITS=116, NUM_WL=15)
REQ-035 SHALL cover full load: write 15 words, pulse cfg_done. Grid pin 0 select=3 -> grid_right_out[0] follows chany_bottom_in[2]. Select=21 -> follows chany_top_in[0]. cfg_active rises one cycle after cfg_done.
REQ-036 SHALL cover early done: 14 words, then cfg_done -> state LOADING, cfg_err=1, outputs 0. Writing word 14 and pulsing cfg_done again -> ACTIVE.
REQ-037 SHALL cover bad wl: wl=15'h0003 -> no word changes, cfg_err=1 next cycle. Writes in ACTIVE are ignored and set cfg_err.
REQ-038 SHALL cover pads: oe[2]=1 with pad-out select=1 -> pad_out[2]=chany_bottom_in[0], io_right_in[2]=0. oe[3]=0 -> io_right_in[3]=pad_in[3]. Select=63 -> pad_out=0.
REQ-039 SHALL cover reset mid-operation: pReset in ACTIVE -> next cycle all routed outputs 0, cfg_active=0, cfg_err=0. Pass-through tracks are unaffected throughout.
REQ-040 SHALL cover readback (CBY_CFG_READBACK_EN defined): after writing 8'hA5 to word 4, rd_wl=1<<4 -> rd_bl=8'hA5 one cycle later.
